// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one external ALU between two requesters.
// Round-robin grant, operands held on alu_* for ALU_LAT cycles, then the
// ALU result and flags are captured and returned on a tagged response channel.
// Illegal opcodes and DIV/MOD by zero are trapped without issuing to the ALU.
module alu_req_arbiter #(
  parameter int unsigned N       = 19,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [2:0]       req0_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [2:0]       req1_op,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  // ALU side
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [N-1:0]     alu_result,
  input  logic [2:0]       alu_flags,
  // statistics
  output logic [CNT_W-1:0] op_count
);

  // Hold counter covers ALU_LAT up to 15.
  localparam int unsigned LAT_W = 4;

  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  logic             rr_ptr;     // 1 = requester 1 has priority on a tie
  logic [LAT_W-1:0] hold_cnt;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel_id;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;
  logic [2:0]       sel_op;
  logic             sel_err;

  // Round-robin grant, only offered while idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Operand/opcode selection for the granted requester and trap detection.
  always_comb begin
    sel_id  = grant1;
    sel_a   = grant1 ? req1_a  : req0_a;
    sel_b   = grant1 ? req1_b  : req0_b;
    sel_op  = grant1 ? req1_op : req0_op;
    sel_err = (sel_op[2:1] == 2'b11) ||
              (((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0));
  end

  // Control FSM with registered ALU operands and response channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      hold_cnt   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 3'b000;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= sel_id;
            rr_ptr <= ~sel_id;
            if (sel_err) begin
              // Trapped op: ALU operands keep their last issued values.
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= 3'b000;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_ctrl <= sel_op;
              hold_cnt <= LAT_W'(ALU_LAT - 1);
              state    <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (hold_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            hold_cnt <= hold_cnt - LAT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed testbench for alu_req_arbiter with a behavioural 19-bit ALU.
module tb_alu_req_arbiter;

  localparam int unsigned N     = 19;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_RES  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [N-1:0]     rsp_result;
  logic [2:0]       rsp_flags;
  logic [N-1:0]     alu_a, alu_b, alu_result;
  logic [2:0]       alu_ctrl, alu_flags;
  logic [CNT_W-1:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  alu_req_arbiter #(.N(N), .ALU_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .op_count(op_count)
  );

  // Behavioural ALU: flags are {Z, O, N}.
  logic [2*N-1:0] prod;
  logic [N-1:0]   m_r;
  logic           m_ov;
  always_comb begin
    prod = alu_a * alu_b;
    m_r  = '0;
    m_ov = 1'b0;
    case (alu_ctrl)
      OP_SUM: begin
        m_r  = alu_a + alu_b;
        m_ov = (alu_a[N-1] == alu_b[N-1]) && (m_r[N-1] != alu_a[N-1]);
      end
      OP_RES: begin
        m_r  = alu_a - alu_b;
        m_ov = (alu_a[N-1] != alu_b[N-1]) && (m_r[N-1] != alu_a[N-1]);
      end
      OP_MULT: m_r = prod[N-1:0];
      OP_DIV:  m_r = (alu_b != '0) ? alu_a / alu_b : '0;
      OP_MOD:  m_r = (alu_b != '0) ? alu_a % alu_b : '0;
      default: m_r = '0;
    endcase
    alu_result = m_r;
    alu_flags  = {(m_r == '0), m_ov, m_r[N-1]};
  end

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op on requester id, confirm the grant, let it be accepted.
  task automatic send(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [2:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    #1;
    check_eq("grant_own",   32'(id ? req1_ready : req0_ready), 32'd1);
    check_eq("grant_other", 32'(id ? req0_ready : req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Wait (bounded) for the response and check latency and payload.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_id,
                          input logic [N-1:0] exp_res, input logic [2:0] exp_fl,
                          input logic exp_err);
    int lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_lat"},   32'(lat),        32'(exp_lat));
    check_eq({tag, "_id"},    32'(rsp_id),     32'(exp_id));
    check_eq({tag, "_res"},   32'(rsp_result), 32'(exp_res));
    check_eq({tag, "_flags"}, 32'(rsp_flags),  32'(exp_fl));
    check_eq({tag, "_err"},   32'(rsp_err),    32'(exp_err));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check_eq("hs_count", 32'(op_count), 32'(exp_cnt));
    check_eq("hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic       grants [4];
    int         n_grant;
    int         n_rsp;
    int         bad_cycles;
    logic [N-1:0] held;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    exp_cnt = '0;
    repeat (3) step();

    // Reset state
    check_eq("rst_valid",  32'(rsp_valid),  32'd0);
    check_eq("rst_count",  32'(op_count),   32'd0);
    check_eq("rst_alu_a",  32'(alu_a),      32'd0);
    check_eq("rst_ctrl",   32'(alu_ctrl),   32'd0);
    check_eq("rst_result", 32'(rsp_result), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: SUM 5+7 on requester 0
    send(1'b0, 19'd5, 19'd7, OP_SUM);
    check_eq("t1_alu_a", 32'(alu_a), 32'd5);
    check_eq("t1_alu_b", 32'(alu_b), 32'd7);
    wait_rsp("t1", 3, 1'b0, 19'd12, 3'b000, 1'b0);
    handshake();

    // 3: DIV by zero on requester 1 is trapped, ALU operands untouched
    send(1'b1, 19'd9, 19'd0, OP_DIV);
    wait_rsp("t3", 1, 1'b1, 19'd0, 3'b000, 1'b1);
    check_eq("t3_ctrl",  32'(alu_ctrl), 32'(OP_SUM));
    check_eq("t3_alu_a", 32'(alu_a),    32'd5);
    handshake();

    // 2: both requesters valid, four back-to-back ops alternate
    req0_a = 19'd1;  req0_b = 19'd2;  req0_op = OP_SUM;
    req1_a = 19'd10; req1_b = 19'd20; req1_op = OP_RES;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_grant = 0; n_rsp = 0; bad_cycles = 0;
    for (int c = 0; c < 100 && n_rsp < 4; c++) begin
      if (req0_ready && req1_ready) bad_cycles++;
      if ((req0_ready || req1_ready) && n_grant < 4) begin
        grants[n_grant] = req1_ready;
        n_grant++;
      end
      if (rsp_valid) begin
        check_eq("t2_rsp_id", 32'(rsp_id), 32'(grants[n_rsp]));
        check_eq("t2_rsp_res", 32'(rsp_result), rsp_id ? 32'd524278 : 32'd3);
        check_eq("t2_rsp_flags", 32'(rsp_flags), rsp_id ? 32'd1 : 32'd0);
        n_rsp++;
        exp_cnt = exp_cnt + 1'b1;
      end
      step();
      if (n_grant >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    check_eq("t2_n_rsp", 32'(n_rsp), 32'd4);
    check_eq("t2_both_ready", 32'(bad_cycles), 32'd0);
    for (int i = 0; i < 4; i++) check_eq("t2_grant_order", 32'(grants[i]), 32'(i % 2));
    check_eq("t2_count", 32'(op_count), 32'(exp_cnt));

    // 4: illegal opcode, then RES 3-3 gives zero flag
    send(1'b0, 19'd4, 19'd4, 3'b110);
    wait_rsp("t4a", 1, 1'b0, 19'd0, 3'b000, 1'b1);
    handshake();
    send(1'b0, 19'd3, 19'd3, OP_RES);
    wait_rsp("t4b", 3, 1'b0, 19'd0, 3'b100, 1'b0);
    handshake();

    // 5: consumer stalls with requester 1 pending
    send(1'b0, 19'd6, 19'd7, OP_MULT);
    wait_rsp("t5a", 3, 1'b0, 19'd42, 3'b000, 1'b0);
    req1_a = 19'd100; req1_b = 19'd7; req1_op = OP_DIV; req1_valid = 1'b1;
    held = rsp_result;
    bad_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!rsp_valid || rsp_result !== held || req1_ready || req0_ready) bad_cycles++;
      step();
    end
    check_eq("t5_stall", 32'(bad_cycles), 32'd0);
    check_eq("t5_held",  32'(rsp_result), 32'd42);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check_eq("t5_count", 32'(op_count), 32'(exp_cnt));
    check_eq("t5_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp("t5b", 3, 1'b1, 19'd14, 3'b000, 1'b0);
    handshake();
    send(1'b1, 19'd100, 19'd7, OP_MOD);
    wait_rsp("t5c", 3, 1'b1, 19'd2, 3'b000, 1'b0);
    handshake();

    // 6: reset while an op is in ISSUE drops it
    send(1'b0, 19'd1, 19'd1, OP_SUM);
    rst_n = 1'b0;
    step();
    check_eq("t6_valid",  32'(rsp_valid),  32'd0);
    check_eq("t6_alu_a",  32'(alu_a),      32'd0);
    check_eq("t6_alu_b",  32'(alu_b),      32'd0);
    check_eq("t6_ctrl",   32'(alu_ctrl),   32'd0);
    check_eq("t6_result", 32'(rsp_result), 32'd0);
    check_eq("t6_count",  32'(op_count),   32'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    bad_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (rsp_valid) bad_cycles++;
    end
    check_eq("t6_no_rsp", 32'(bad_cycles), 32'd0);
    // Pointer favours requester 0 after reset
    req0_a = 19'd2; req0_b = 19'd2; req0_op = OP_SUM;
    req1_a = 19'd8; req1_b = 19'd1; req1_op = OP_SUM;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("t6_ptr_r0", 32'(req0_ready), 32'd1);
    check_eq("t6_ptr_r1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp("t6a", 3, 1'b0, 19'd4, 3'b000, 1'b0);
    handshake();
    // Counter wraps modulo 4
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 19'(k), 19'd1, OP_SUM);
      wait_rsp("t6w", 3, 1'b1, 19'(k + 1), 3'b000, 1'b0);
      handshake();
    end
    check_eq("t6_wrap", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
